rotor_wiring_loader: RTL and testbench

- Programmable rotor wiring store for the Enigma datapath. It is the write side of the rotor wiring lookup, and it replaces fixed wiring tables with run-time loaded ones.
- Accepts a 26-symbol permutation per rotor slot over a valid/ready stream and validates that it is a true permutation.
- Derives the inverse (reverse-path) table in hardware, so only the forward wiring is ever supplied.
- Serves registered forward/reverse lookups to the rotor stepping and encryption pipeline.

---
 rtl/enigma_pkg.sv | 40 ++++
 rtl/rotor_table_bank.sv | 62 ++++++
 rtl/rotor_wiring_loader.sv | 155 +++++++++++++++
 tb/tb_rotor_wiring_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma datapath.
//   SYMBOLS/LAST_SYM : alphabet size and last valid symbol code
//   symbol_t/slot_t  : symbol code and rotor slot index
//   wiring_t         : one full 26-entry wiring table
//   loader_state_t   : rotor wiring loader FSM states
//   commit_t         : atomic table-commit payload from loader to table bank
package enigma_pkg;

   localparam int unsigned SYMBOLS   = 26;
   localparam int unsigned LAST_SYM  = 25;
   localparam int unsigned NUM_SLOTS = 8;
   localparam int unsigned SYM_W     = 5;
   localparam int unsigned SLOT_W    = 3;

   typedef logic [SYM_W-1:0]              symbol_t;
   typedef logic [SLOT_W-1:0]             slot_t;
   typedef logic [SYMBOLS-1:0][SYM_W-1:0] wiring_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CHECK = 2'd2
   } loader_state_t;

   typedef struct packed {
      logic    valid;
      slot_t   slot;
      wiring_t wiring;
   } commit_t;

   // Identity wiring: entry i maps to i.
   function automatic wiring_t identity_wiring();
      wiring_t w;
      for (int i = 0; i < SYMBOLS; i++) begin
         w[i] = symbol_t'(i);
      end
      return w;
   endfunction

endpackage

// File: rtl/rotor_table_bank.sv
// Forward and inverse rotor wiring tables for all slots.
//   clk, reset : system clock, synchronous active-high reset (tables -> identity)
//   commit     : atomic write of one slot's full forward table; inverse derived here
//   lk_code, lk_slot, lk_reverse : lookup request
//   lk_val     : registered lookup result (0 for out-of-range codes)
module rotor_table_bank
   import enigma_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  commit_t commit,
   input  symbol_t lk_code,
   input  slot_t   lk_slot,
   input  logic    lk_reverse,
   output symbol_t lk_val
);

   wiring_t fwd_q [NUM_SLOTS];
   wiring_t fwd_d [NUM_SLOTS];
   wiring_t inv_q [NUM_SLOTS];
   wiring_t inv_d [NUM_SLOTS];
   symbol_t lk_val_q;
   symbol_t lk_val_d;

   // Table update: identity on reset, otherwise whole-slot commit.
   always_comb begin : table_next
      fwd_d = fwd_q;
      inv_d = inv_q;
      if (reset) begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            fwd_d[s] = identity_wiring();
            inv_d[s] = identity_wiring();
         end
      end else if (commit.valid) begin
         fwd_d[commit.slot] = commit.wiring;
         // Commit only happens for a validated permutation; the guard just keeps
         // the scatter index in range.
         for (int i = 0; i < SYMBOLS; i++) begin
            if (commit.wiring[i] <= symbol_t'(LAST_SYM)) begin
               inv_d[commit.slot][commit.wiring[i]] = symbol_t'(i);
            end
         end
      end
   end

   // Lookup reads current (pre-commit) contents, giving read-before-write.
   always_comb begin : lookup_next
      lk_val_d = '0;
      if (!reset && (lk_code <= symbol_t'(LAST_SYM))) begin
         lk_val_d = lk_reverse ? inv_q[lk_slot][lk_code] : fwd_q[lk_slot][lk_code];
      end
   end

   always_ff @(posedge clk) begin : regs
      fwd_q    <= fwd_d;
      inv_q    <= inv_d;
      lk_val_q <= lk_val_d;
   end

   assign lk_val = lk_val_q;

endmodule

// File: rtl/rotor_wiring_loader.sv
// Run-time loader for Enigma rotor wiring slots.
//   clk, reset   : system clock, synchronous active-high reset
//   load_start/load_slot : begin loading a slot (honoured only when idle)
//   load_valid/load_data/load_ready : 26-beat forward wiring stream, position 0 first
//   load_done/load_error : one-cycle result pulse (committed / rejected)
//   busy         : loader is in LOAD or CHECK
//   lk_code/lk_slot/lk_reverse/lk_val : registered forward/inverse lookup
module rotor_wiring_loader
   import enigma_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    load_start,
   input  slot_t   load_slot,
   input  logic    load_valid,
   input  symbol_t load_data,
   output logic    load_ready,
   output logic    load_done,
   output logic    load_error,
   output logic    busy,
   input  symbol_t lk_code,
   input  slot_t   lk_slot,
   input  logic    lk_reverse,
   output symbol_t lk_val
);

   loader_state_t        state_q, state_d;
   slot_t                slot_q, slot_d;
   symbol_t              idx_q, idx_d;
   logic [SYMBOLS-1:0]   seen_q, seen_d;
   logic                 err_q, err_d;
   wiring_t              staging_q, staging_d;
   logic                 load_ready_q, load_ready_d;
   logic                 load_done_q, load_done_d;
   logic                 load_error_q, load_error_d;
   logic                 busy_q, busy_d;

   logic                 beat_acc_c;
   logic                 beat_bad_c;
   commit_t              commit_c;

   assign beat_acc_c = (state_q == LOAD) && load_valid && load_ready_q;

   // A beat is bad if out of range or already used earlier in this transfer.
   always_comb begin : beat_check
      beat_bad_c = 1'b1;
      if (load_data <= symbol_t'(LAST_SYM)) begin
         beat_bad_c = seen_q[load_data];
      end
   end

   always_ff @(posedge clk) begin : state_reg
      state_q <= state_d;
   end

   always_comb begin : fsm_next
      state_d = state_q;
      if (reset) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (load_start) state_d = LOAD;
            LOAD:    if (beat_acc_c && (idx_q == symbol_t'(LAST_SYM))) state_d = CHECK;
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Datapath and registered outputs.
   always_comb begin : fsm_out
      slot_d       = slot_q;
      idx_d        = idx_q;
      seen_d       = seen_q;
      err_d        = err_q;
      staging_d    = staging_q;
      load_done_d  = 1'b0;
      load_error_d = 1'b0;
      load_ready_d = (state_d == LOAD);
      busy_d       = (state_d != IDLE);

      commit_c        = '0;
      commit_c.slot   = slot_q;
      commit_c.wiring = staging_q;

      if (reset) begin
         slot_d       = '0;
         idx_d        = '0;
         seen_d       = '0;
         err_d        = 1'b0;
         staging_d    = '0;
         load_ready_d = 1'b0;
         busy_d       = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (load_start) begin
                  slot_d = load_slot;
                  idx_d  = '0;
                  seen_d = '0;
                  err_d  = 1'b0;
               end
            end
            LOAD: begin
               if (beat_acc_c) begin
                  staging_d[idx_q] = load_data;
                  if (beat_bad_c) begin
                     err_d = 1'b1;
                  end else begin
                     seen_d[load_data] = 1'b1;
                  end
                  // Terminal count holds; no wrap past the last position.
                  if (idx_q != symbol_t'(LAST_SYM)) begin
                     idx_d = idx_q + symbol_t'(1);
                  end
               end
            end
            CHECK: begin
               commit_c.valid = !err_q;
               load_done_d    = !err_q;
               load_error_d   = err_q;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin : data_regs
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      seen_q       <= seen_d;
      err_q        <= err_d;
      staging_q    <= staging_d;
      load_ready_q <= load_ready_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
      busy_q       <= busy_d;
   end

   assign load_ready = load_ready_q;
   assign load_done  = load_done_q;
   assign load_error = load_error_q;
   assign busy       = busy_q;

   rotor_table_bank u_bank (
      .clk        (clk),
      .reset      (reset),
      .commit     (commit_c),
      .lk_code    (lk_code),
      .lk_slot    (lk_slot),
      .lk_reverse (lk_reverse),
      .lk_val     (lk_val)
   );

endmodule

// File: tb/tb_rotor_wiring_loader.sv
// Self-checking bench for rotor_wiring_loader against a table-level model.
module tb_rotor_wiring_loader;
   import enigma_pkg::*;

   logic    clk = 1'b0;
   logic    reset;
   logic    load_start;
   slot_t   load_slot;
   logic    load_valid;
   symbol_t load_data;
   logic    load_ready;
   logic    load_done;
   logic    load_error;
   logic    busy;
   symbol_t lk_code;
   slot_t   lk_slot;
   logic    lk_reverse;
   symbol_t lk_val;

   int checks = 0;
   int errors = 0;
   int fwd_m [NUM_SLOTS][SYMBOLS];
   int lk_fix_slot = -1;

   always #5 clk = ~clk;

   rotor_wiring_loader dut (
      .clk        (clk),
      .reset      (reset),
      .load_start (load_start),
      .load_slot  (load_slot),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .load_done  (load_done),
      .load_error (load_error),
      .busy       (busy),
      .lk_code    (lk_code),
      .lk_slot    (lk_slot),
      .lk_reverse (lk_reverse),
      .lk_val     (lk_val)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < NUM_SLOTS; s++)
         for (int i = 0; i < SYMBOLS; i++)
            fwd_m[s][i] = i;
   endtask

   // Inverse found by searching the forward table.
   function automatic int model_lookup(input int slot, input int code, input bit rev);
      if (code > 25) return 0;
      if (!rev) return fwd_m[slot][code];
      for (int j = 0; j < SYMBOLS; j++)
         if (fwd_m[slot][j] == code) return j;
      return -1;
   endfunction

   function automatic bit is_perm(input int w [SYMBOLS]);
      int cnt [SYMBOLS];
      for (int i = 0; i < SYMBOLS; i++) cnt[i] = 0;
      for (int i = 0; i < SYMBOLS; i++) begin
         if (w[i] < 0 || w[i] > 25) return 1'b0;
         cnt[w[i]]++;
      end
      for (int i = 0; i < SYMBOLS; i++)
         if (cnt[i] != 1) return 1'b0;
      return 1'b1;
   endfunction

   task automatic rand_perm(output int w [SYMBOLS]);
      int j, t;
      for (int i = 0; i < SYMBOLS; i++) w[i] = i;
      for (int i = SYMBOLS - 1; i > 0; i--) begin
         j = int'($urandom_range(0, i));
         t = w[i]; w[i] = w[j]; w[j] = t;
      end
   endtask

   // One clock; checks the lookup sampled in the cycle just ended.
   task automatic step(input bit rnd);
      int exp;
      if (rnd) begin
         lk_slot    = (lk_fix_slot < 0) ? slot_t'($urandom_range(0, 7)) : slot_t'(lk_fix_slot);
         lk_code    = symbol_t'($urandom_range(0, 31));
         lk_reverse = 1'($urandom_range(0, 1));
      end
      exp = reset ? 0 : model_lookup(int'(lk_slot), int'(lk_code), lk_reverse);
      @(posedge clk);
      #1;
      if (reset) model_reset();
      check_eq("lk_val", 32'(lk_val), 32'(exp));
   endtask

   task automatic send_beats(input int w [SYMBOLS], input int n, input int gap_pct,
                             input int extra_at);
      int  acc;
      int  cyc;
      bit  v;
      bit  extra_done;
      acc = 0; cyc = 0; extra_done = 1'b0;
      while (acc < n && cyc < 400) begin
         v          = ($urandom_range(0, 99) >= gap_pct);
         load_valid = v;
         load_data  = symbol_t'(w[acc]);
         load_start = 1'b0;
         if (!extra_done && acc == extra_at) begin
            load_start = 1'b1;
            load_slot  = slot_t'(6);
            extra_done = 1'b1;
         end
         step(1);
         if (v) acc++;
         cyc++;
         check_eq("load_ready", 32'(load_ready), 32'(acc < SYMBOLS));
         check_eq("busy_in_load", 32'(busy), 32'(1));
         check_eq("no_pulse_in_load", 32'({load_done, load_error}), 32'(0));
      end
      load_valid = 1'b0;
      load_start = 1'b0;
      if (acc < n) check_eq("beat_timeout", 32'(acc), 32'(n));
   endtask

   task automatic load_wiring(input int slot, input int w [SYMBOLS], input int gap_pct,
                              input int extra_at);
      bit ok;
      ok = is_perm(w);
      load_slot  = slot_t'(slot);
      load_start = 1'b1;
      step(1);
      load_start = 1'b0;
      check_eq("start_busy", 32'(busy), 32'(1));
      check_eq("start_ready", 32'(load_ready), 32'(1));
      send_beats(w, SYMBOLS, gap_pct, extra_at);
      // Now in the CHECK cycle: lookup here must see the old table.
      check_eq("check_busy", 32'(busy), 32'(1));
      lk_slot    = slot_t'(slot);
      lk_code    = symbol_t'($urandom_range(0, 25));
      lk_reverse = 1'($urandom_range(0, 1));
      step(0);
      check_eq("done_pulse", 32'(load_done), 32'(ok));
      check_eq("error_pulse", 32'(load_error), 32'(!ok));
      check_eq("pulse_busy", 32'(busy), 32'(0));
      if (ok) fwd_m[slot] = w;
      // Lookup sampled in the pulse cycle must see the new table.
      step(0);
      check_eq("pulse_single", 32'({load_done, load_error}), 32'(0));
   endtask

   initial begin
      int w [SYMBOLS];
      reset = 1'b1; load_start = 1'b0; load_slot = '0; load_valid = 1'b0;
      load_data = '0; lk_code = '0; lk_slot = '0; lk_reverse = 1'b0;
      model_reset();
      step(1);
      step(1);
      reset = 1'b0;
      check_eq("rst_busy", 32'(busy), 32'(0));
      check_eq("rst_ready", 32'(load_ready), 32'(0));
      check_eq("rst_pulses", 32'({load_done, load_error}), 32'(0));

      // Test 1: identity after reset
      lk_slot = slot_t'(3); lk_code = symbol_t'(7); lk_reverse = 1'b0;
      step(0);
      check_eq("t1_fwd", 32'(lk_val), 32'(7));
      lk_reverse = 1'b1;
      step(0);
      check_eq("t1_rev", 32'(lk_val), 32'(7));
      check_eq("t1_busy", 32'(busy), 32'(0));

      // Test 2: valid load into slot 0
      w = '{4,10,12,5,11,6,3,16,21,25,13,19,14,22,24,7,23,20,18,15,0,8,1,17,2,9};
      load_wiring(0, w, 0, -1);
      lk_slot = slot_t'(0);
      lk_code = symbol_t'(0);  lk_reverse = 1'b0; step(0); check_eq("t2_f0", 32'(lk_val), 32'(4));
      lk_code = symbol_t'(25); lk_reverse = 1'b0; step(0); check_eq("t2_f25", 32'(lk_val), 32'(9));
      lk_code = symbol_t'(4);  lk_reverse = 1'b1; step(0); check_eq("t2_r4", 32'(lk_val), 32'(0));
      lk_code = symbol_t'(0);  lk_reverse = 1'b1; step(0); check_eq("t2_r0", 32'(lk_val), 32'(20));
      lk_code = symbol_t'(30); lk_reverse = 1'b0; step(0); check_eq("t2_oor", 32'(lk_val), 32'(0));

      // Test 3: duplicate on the last beat
      for (int i = 0; i < SYMBOLS; i++) w[i] = i;
      w[25] = 5;
      load_wiring(1, w, 0, -1);
      lk_slot = slot_t'(1); lk_code = symbol_t'(25); lk_reverse = 1'b0;
      step(0); check_eq("t3_f25", 32'(lk_val), 32'(25));
      lk_slot = slot_t'(0); lk_code = symbol_t'(0);
      step(0); check_eq("t3_s0", 32'(lk_val), 32'(4));

      // Test 4: out-of-range value mid-stream
      for (int i = 0; i < SYMBOLS; i++) w[i] = i;
      w[10] = 26;
      load_wiring(2, w, 0, -1);
      lk_slot = slot_t'(2); lk_code = symbol_t'(10); lk_reverse = 1'b1;
      step(0); check_eq("t4_r10", 32'(lk_val), 32'(10));

      // Test 5: gaps, stray start, continuous slot-0 lookups
      rand_perm(w);
      lk_fix_slot = 0;
      load_wiring(4, w, 40, 7);
      lk_fix_slot = -1;
      lk_slot = slot_t'(6); lk_code = symbol_t'(3); lk_reverse = 1'b0;
      step(0); check_eq("t5_s6", 32'(lk_val), 32'(3));
      check_eq("t5_idle", 32'(busy), 32'(0));
      lk_slot = slot_t'(4); lk_code = symbol_t'(11); lk_reverse = 1'b0;
      step(0); check_eq("t5_s4", 32'(lk_val), 32'(w[11]));

      // Test 6: reset after 13 beats
      rand_perm(w);
      load_slot = slot_t'(5); load_start = 1'b1;
      step(1);
      load_start = 1'b0;
      send_beats(w, 13, 20, -1);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check_eq("t6_busy", 32'(busy), 32'(0));
      check_eq("t6_ready", 32'(load_ready), 32'(0));
      lk_slot = slot_t'(5); lk_code = symbol_t'(9); lk_reverse = 1'b0;
      step(0); check_eq("t6_s5", 32'(lk_val), 32'(9));
      lk_slot = slot_t'(0); lk_code = symbol_t'(0); lk_reverse = 1'b1;
      step(0); check_eq("t6_s0", 32'(lk_val), 32'(0));
      repeat (3) step(1);

      // Random loads, some corrupted
      for (int k = 0; k < 8; k++) begin
         rand_perm(w);
         if ($urandom_range(0, 1) == 1) w[$urandom_range(0, 25)] = int'($urandom_range(0, 31));
         load_wiring(int'($urandom_range(0, 7)), w, 30, -1);
         repeat (int'($urandom_range(0, 3))) step(1);
      end
      repeat (20) step(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
